// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO bank: register map and bus data width.
package gpio_pkg;

    localparam int unsigned BUS_DW = 32;

    localparam logic [1:0] GPIO_DATA       = 2'd0;
    localparam logic [1:0] GPIO_DIR        = 2'd1;
    localparam logic [1:0] GPIO_IRQ_EN     = 2'd2;
    localparam logic [1:0] GPIO_IRQ_STATUS = 2'd3;

endpackage

// File: rtl/gpio_in_cond.sv
// Per-pin input conditioning: synchroniser, optional debounce (GPIO_DEBOUNCE_EN),
// previous-value register and rising-edge pulse.
module gpio_in_cond #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic pin_i,
    output logic val_o,
    output logic rise_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_c;
    logic                   cond_c;
    logic                   prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
        end
    end

    assign sync_c = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             deb_q, deb_d;

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES consecutive cycles.
    always_comb begin
        cnt_d = cnt_q;
        deb_d = deb_q;
        if (sync_c == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            deb_d = sync_c;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            deb_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            deb_q <= deb_d;
        end
    end

    assign cond_c = deb_q;
`else
    localparam int unsigned unused_debounce_cycles = DEBOUNCE_CYCLES;

    assign cond_c = sync_c;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= cond_c;
        end
    end

    assign val_o  = cond_c;
    assign rise_c = cond_c & ~prev_q;

endmodule

// File: rtl/gpio_bank.sv
// Four-register GPIO port with direction, output latch, synchronised readback and
// rising-edge interrupts. Optional per-pin debounce under GPIO_DEBOUNCE_EN.
module gpio_bank
    import gpio_pkg::*;
#(
    parameter int unsigned NUM_GPIO        = 8,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stb,
    input  logic                we,
    input  logic [1:0]          addr,
    input  logic [BUS_DW-1:0]   data_in,
    output logic [BUS_DW-1:0]   data_out,
    output logic                ack,
    input  logic [NUM_GPIO-1:0] io_in,
    output logic [NUM_GPIO-1:0] io_out,
    output logic [NUM_GPIO-1:0] io_t,
    output logic                irq
);

    logic [NUM_GPIO-1:0] pin_val_c;
    logic [NUM_GPIO-1:0] rise_c;

    for (genvar g = 0; g < NUM_GPIO; g++) begin : g_pin
        gpio_in_cond #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_in_cond (
            .clk    (clk),
            .rst    (rst),
            .pin_i  (io_in[g]),
            .val_o  (pin_val_c[g]),
            .rise_c (rise_c[g])
        );
    end

    logic [NUM_GPIO-1:0] out_q, out_d;
    logic [NUM_GPIO-1:0] dir_q, dir_d;
    logic [NUM_GPIO-1:0] tri_q, tri_d;
    logic [NUM_GPIO-1:0] en_q, en_d;
    logic [NUM_GPIO-1:0] st_q, st_d;
    logic [BUS_DW-1:0]   rdata_q, rdata_d;
    logic                ack_q, ack_d;
    logic                irq_q, irq_d;

    logic                wr_c;
    logic                rd_c;
    logic [NUM_GPIO-1:0] wdata_c;
    logic [NUM_GPIO-1:0] w1c_c;
    logic                unused_data_in;

    assign wr_c           = stb & we;
    assign rd_c           = stb & ~we;
    assign wdata_c        = data_in[NUM_GPIO-1:0];
    assign unused_data_in = ^data_in;
    assign w1c_c          = (wr_c && addr == GPIO_IRQ_STATUS) ? wdata_c : '0;

    // Register writes, W1C with edge-set priority, and read-data capture.
    always_comb begin
        out_d   = out_q;
        dir_d   = dir_q;
        tri_d   = tri_q;
        en_d    = en_q;
        rdata_d = rdata_q;
        ack_d   = stb;
        irq_d   = |(st_q & en_q);
        st_d    = (st_q & ~w1c_c) | (rise_c & en_q);

        if (wr_c) begin
            case (addr)
                GPIO_DATA: out_d = wdata_c;
                GPIO_DIR: begin
                    dir_d = wdata_c;
                    tri_d = ~wdata_c;
                end
                GPIO_IRQ_EN: en_d = wdata_c;
                default: ;
            endcase
        end

        if (rd_c) begin
            case (addr)
                GPIO_DATA:       rdata_d = BUS_DW'(pin_val_c);
                GPIO_DIR:        rdata_d = BUS_DW'(dir_q);
                GPIO_IRQ_EN:     rdata_d = BUS_DW'(en_q);
                GPIO_IRQ_STATUS: rdata_d = BUS_DW'(st_q);
                default:         rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q   <= '0;
            dir_q   <= '0;
            tri_q   <= '1;
            en_q    <= '0;
            st_q    <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            out_q   <= out_d;
            dir_q   <= dir_d;
            tri_q   <= tri_d;
            en_q    <= en_d;
            st_q    <= st_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            irq_q   <= irq_d;
        end
    end

    assign io_out   = out_q;
    assign io_t     = tri_q;
    assign data_out = rdata_q;
    assign ack      = ack_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_gpio_bank.sv
// Directed bench for gpio_bank: register table, loopback, edge/IRQ, W1C collision,
// reset, narrow instance and (with GPIO_DEBOUNCE_EN) debounce timing.
module tb_gpio_bank;

    localparam int unsigned S = 2;
    localparam int unsigned D = 16;
`ifdef GPIO_DEBOUNCE_EN
    localparam int unsigned LAT = S + D;
`else
    localparam int unsigned LAT = S;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        stb, we;
    logic [1:0]  addr;
    logic [31:0] data_in, data_out;
    logic        ack, irq;
    logic [7:0]  io_in, io_out, io_t;

    logic        stb4, we4;
    logic [1:0]  addr4;
    logic [31:0] data_in4, data_out4;
    logic        ack4, irq4;
    logic [3:0]  io_in4, io_out4, io_t4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gpio_bank #(.NUM_GPIO(8), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) u_dut (
        .clk(clk), .rst(rst), .stb(stb), .we(we), .addr(addr),
        .data_in(data_in), .data_out(data_out), .ack(ack),
        .io_in(io_in), .io_out(io_out), .io_t(io_t), .irq(irq)
    );

    gpio_bank #(.NUM_GPIO(4), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) u_dut4 (
        .clk(clk), .rst(rst), .stb(stb4), .we(we4), .addr(addr4),
        .data_in(data_in4), .data_out(data_out4), .ack(ack4),
        .io_in(io_in4), .io_out(io_out4), .io_t(io_t4), .irq(irq4)
    );

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic [7:0]  exp_out;
        logic [7:0]  exp_t;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the ack cycle.
    task automatic bus(input logic w, input logic [1:0] a, input logic [31:0] d,
                       output logic [31:0] r);
        stb = 1'b1; we = w; addr = a; data_in = d;
        @(posedge clk); #1;
        stb = 1'b0; we = 1'b0;
        check("ack", 32'(ack), 32'd1);
        r = data_out;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [31:0] r;

    initial begin
        rst = 1'b1; stb = 1'b0; we = 1'b0; addr = 2'd0; data_in = '0; io_in = '0;
        stb4 = 1'b0; we4 = 1'b0; addr4 = 2'd0; data_in4 = '0; io_in4 = '0;

        vecs[0] = '{1'b0, 2'd0, 32'h0,        32'h0,  8'h00, 8'hFF};
        vecs[1] = '{1'b0, 2'd1, 32'h0,        32'h0,  8'h00, 8'hFF};
        vecs[2] = '{1'b0, 2'd2, 32'h0,        32'h0,  8'h00, 8'hFF};
        vecs[3] = '{1'b0, 2'd3, 32'h0,        32'h0,  8'h00, 8'hFF};
        vecs[4] = '{1'b1, 2'd1, 32'h0F,       32'h0,  8'h00, 8'hF0};
        vecs[5] = '{1'b1, 2'd0, 32'hA5,       32'h0,  8'hA5, 8'hF0};
        vecs[6] = '{1'b0, 2'd1, 32'h0,        32'h0F, 8'hA5, 8'hF0};
        vecs[7] = '{1'b1, 2'd1, 32'hFFFF_FF0F, 32'h0, 8'hA5, 8'hF0};
        vecs[8] = '{1'b0, 2'd1, 32'h0,        32'h0F, 8'hA5, 8'hF0};
        vecs[9] = '{1'b0, 2'd0, 32'h0,        32'h0,  8'hA5, 8'hF0};

        tick(3);
        rst = 1'b0;
        check("rst_io_out", 32'(io_out), 32'h00);
        check("rst_io_t", 32'(io_t), 32'hFF);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_data_out", data_out, 32'h0);

        for (int i = 0; i < 10; i++) begin
            bus(vecs[i].we, vecs[i].addr, vecs[i].wdata, r);
            if (!vecs[i].we) check($sformatf("vec%0d_rd", i), r, vecs[i].exp_rd);
            check($sformatf("vec%0d_io_out", i), 32'(io_out), 32'(vecs[i].exp_out));
            check($sformatf("vec%0d_io_t", i), 32'(io_t), 32'(vecs[i].exp_t));
        end
        tick(1);
        check("ack_one_cycle", 32'(ack), 32'd0);
        check("data_out_hold", data_out, 32'h0);

        // Loopback of the pad outputs
        io_in = io_out;
        tick(LAT);
        bus(1'b0, 2'd0, 32'h0, r);
        check("loopback_data", r, 32'h0000_00A5);
        check("loopback_lo_nibble", 32'(r[3:0]), 32'h5);

        io_in = '0;
        tick(LAT + 2);
        bus(1'b1, 2'd2, 32'h01, r);
        bus(1'b1, 2'd3, 32'hFF, r);
        tick(2);

        // Enabled rising edge on pin 0: status at LAT+1, irq one cycle later
        io_in[0] = 1'b1;
        tick(LAT + 1);
        check("irq_before", 32'(irq), 32'd0);
        tick(1);
        check("irq_after", 32'(irq), 32'd1);
        bus(1'b0, 2'd3, 32'h0, r);
        check("status_pin0", r, 32'h01);

        // Disabled pin 1 edge never sets status
        io_in[1] = 1'b1;
        tick(LAT + 3);
        bus(1'b0, 2'd3, 32'h0, r);
        check("status_pin1_disabled", r, 32'h01);

        // W1C coinciding with a new edge on pin 0: set wins
        io_in[0] = 1'b0;
        tick(LAT + 3);
        io_in[0] = 1'b1;
        tick(LAT);
        bus(1'b1, 2'd3, 32'h01, r);
        bus(1'b0, 2'd3, 32'h0, r);
        check("w1c_collision_status", r, 32'h01);
        check("w1c_collision_irq", 32'(irq), 32'd1);

        // W1C of a zero bit leaves status, then a real clear
        bus(1'b1, 2'd3, 32'hFE, r);
        bus(1'b0, 2'd3, 32'h0, r);
        check("w1c_zero_bit", r, 32'h01);
        bus(1'b1, 2'd3, 32'h01, r);
        check("irq_hold_after_clear", 32'(irq), 32'd1);
        tick(1);
        check("irq_cleared", 32'(irq), 32'd0);
        bus(1'b0, 2'd3, 32'h0, r);
        check("status_cleared", r, 32'h0);

        // Clearing IRQ_EN drops irq but keeps status
        io_in[0] = 1'b0;
        tick(LAT + 3);
        io_in[0] = 1'b1;
        tick(LAT + 3);
        check("irq_re_set", 32'(irq), 32'd1);
        bus(1'b1, 2'd2, 32'h00, r);
        tick(1);
        check("irq_en_off", 32'(irq), 32'd0);
        bus(1'b0, 2'd3, 32'h0, r);
        check("status_kept_en_off", r, 32'h01);

        // Asynchronous reset mid-operation with pins held high
        #3 rst = 1'b1;
        #1;
        check("async_rst_io_out", 32'(io_out), 32'h00);
        check("async_rst_io_t", 32'(io_t), 32'hFF);
        check("async_rst_irq", 32'(irq), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus(1'b0, 2'd1, 32'h0, r);
        check("post_rst_dir", r, 32'h0);
        tick(LAT + 3);
        bus(1'b1, 2'd2, 32'hFF, r);
        tick(LAT + 3);
        check("held_pin_no_irq", 32'(irq), 32'd0);
        bus(1'b0, 2'd3, 32'h0, r);
        check("held_pin_no_status", r, 32'h0);

        // Narrow instance: upper write bits dropped on readback
        stb4 = 1'b1; we4 = 1'b1; addr4 = 2'd1; data_in4 = 32'hFFFF_FFFF;
        tick(1);
        stb4 = 1'b0; we4 = 1'b0;
        check("n4_io_t", 32'(io_t4), 32'h0);
        stb4 = 1'b1; addr4 = 2'd1;
        tick(1);
        stb4 = 1'b0;
        check("n4_ack", 32'(ack4), 32'd1);
        check("n4_dir_read", data_out4, 32'h0000_000F);

`ifdef GPIO_DEBOUNCE_EN
        io_in = '0;
        tick(LAT + 3);
        bus(1'b1, 2'd3, 32'hFF, r);
        io_in[0] = 1'b1;
        tick(10);
        io_in[0] = 1'b0;
        tick(LAT + 5);
        bus(1'b0, 2'd0, 32'h0, r);
        check("deb_glitch_data", r, 32'h0);
        bus(1'b0, 2'd3, 32'h0, r);
        check("deb_glitch_status", r, 32'h0);

        io_in[0] = 1'b1;
        tick(LAT - 1);
        bus(1'b0, 2'd0, 32'h0, r);
        check("deb_data_early", r, 32'h0);
        bus(1'b0, 2'd0, 32'h0, r);
        check("deb_data_valid", r, 32'h01);
        tick(30);
        bus(1'b0, 2'd3, 32'h0, r);
        check("deb_status_set", r, 32'h01);
        bus(1'b1, 2'd3, 32'h01, r);
        tick(30);
        bus(1'b0, 2'd3, 32'h0, r);
        check("deb_status_once", r, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gpio_bank.md
Name: gpio_bank

Overview:
- Parametrised GPIO port of NUM_GPIO pins with a per-pin direction register, an output latch, synchronised input readback, and rising-edge capture with an interrupt.
- Drives external Xilinx-style pad buffers through separate out/in/tristate vectors: io_out to I, io_in from O, io_t to T.
- Sits on the processor IO bus as a four-register device, one clock domain.

Parameters:
- NUM_GPIO, 8, number of pins, 1..32.
- SYNC_STAGES, 2, input synchroniser depth, >=2.
- DEBOUNCE_CYCLES, 16, stable-input cycles required when GPIO_DEBOUNCE_EN is defined, >=2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- stb  in  1  bus transfer strobe, one cycle per transfer.
- we  in  1  1 = write, 0 = read; sampled with stb.
- addr  in  2  register select.
- data_in  in  32  write data.
- data_out  out  32  read data, valid while ack=1.
- ack  out  1  transfer acknowledge.
- io_in  in  NUM_GPIO  pad input values (asynchronous).
- io_out  out  NUM_GPIO  pad output values.
- io_t  out  NUM_GPIO  tristate control, 1 = pin high-Z.
- irq  out  1  level interrupt request.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: io_out=0, io_t=all 1 (all inputs), data_out=0, ack=0, irq=0. DIR, OUT, IRQ_EN, IRQ_STATUS, synchroniser and edge registers all clear.
- Registers:
  - addr 0 DATA: write loads OUT; read returns the synchronised pin values for all pins, including output pins read back through the pad.
  - addr 1 DIR: 1 = output; read/write.
  - addr 2 IRQ_EN: read/write.
  - addr 3 IRQ_STATUS: read; write-1-to-clear.
- Width: only data_in[NUM_GPIO-1:0] is used; read bits [31:NUM_GPIO] return 0.
- Bus timing:
  - ack=1 exactly one cycle after each stb, for one cycle.
  - data_out is registered in the same cycle and holds its value until the next read.
  - Back-to-back stb accepted every cycle.
  - Writes take effect on the clock edge where stb is sampled, so io_out and io_t change one cycle after stb.
- Outputs: io_out = OUT, io_t = ~DIR, both registered.
- Input path: SYNC_STAGES flops per pin. The edge register holds the previous synchronised value. Pin-to-DATA-readback latency is SYNC_STAGES cycles, plus 1 cycle for the bus read.
- Edge capture:
  - A rising edge (sync=1, prev=0) on pin i with IRQ_EN[i]=1 sets IRQ_STATUS[i].
  - Bits whose IRQ_EN=0 never set. Clearing IRQ_EN does not clear STATUS.
- Simultaneous edge-set and W1C on the same bit: set wins, bit stays 1. W1C with a 0 bit leaves that bit unchanged.
- irq is registered: irq = |(IRQ_STATUS & IRQ_EN), so it follows a status change by 1 cycle.
- Reset mid-operation clears everything immediately. A pin held high through reset causes no interrupt because IRQ_EN=0.
- Pins configured as output still run edge detection on their read-back value.

Optional Feature:
- Macro GPIO_DEBOUNCE_EN.
- Defined:
  - Each pin gets a counter after the synchroniser. The debounced value updates only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - The counter resets to 0 whenever the input equals the debounced value.
  - DATA readback and edge detection use the debounced value.
  - Added latency = DEBOUNCE_CYCLES cycles.
  - Debounced value resets to 0.
- Undefined: synchronised value used directly; no counters are generated.

Decomposition:
- Package gpio_pkg holds register address constants (GPIO_DATA=0, GPIO_DIR=1, GPIO_IRQ_EN=2, GPIO_IRQ_STATUS=3) and the bus data width constant 32.
- One sub-module gpio_in_cond, instantiated per pin: synchroniser, optional debounce, previous-value register, rise pulse output.
- Pad IOBUF instances live at board top level, not inside gpio_bank.

Test Plan:
- Reset, then read all four registers -> data_out=0 each with ack one cycle after stb; io_t=8'hFF, io_out=0, irq=0.
- Write DIR=8'h0F, DATA=8'hA5 -> next cycle io_t=8'hF0, io_out=8'hA5. Loop io_out back to io_in, then read DATA after SYNC_STAGES cycles -> low nibble reads 4'h5.
- IRQ_EN=8'h01; drive io_in[0] 0->1 -> STATUS[0]=1 after SYNC_STAGES+1 cycles, irq=1 one cycle later. Same edge on pin 1 (disabled) -> STATUS[1] stays 0.
- Write STATUS=8'h01 in the same cycle a new rising edge on pin 0 registers -> STATUS[0] stays 1, irq stays 1. Clear with no edge -> STATUS=0, irq=0 next cycle.
- NUM_GPIO=4; write data_in=32'hFFFF_FFFF to DIR -> readback 32'h0000_000F.
- With GPIO_DEBOUNCE_EN and DEBOUNCE_CYCLES=16:
  - 10-cycle high glitch -> no DATA change, no STATUS set.
  - 20-cycle high -> DATA bit=1 after SYNC_STAGES+16 cycles, STATUS set once.
